axi_aw_arb3: RTL and testbench

- 3-to-1 AXI write-address arbiter feeding the DDR3 controller AW port; the arbiter whose grants the AW SVA checker monitors on ports axi0/axi1/axi2.
- Modes: fixed priority, round robin, weighted round robin; mode and weights come from ddr3_reg (arb_mode, WEIGHT_SETTING0..2).
- Single-entry registered output slice; emits source index so downstream W/B routing follows AW grant order.

---
 rtl/axi_aw_arb3_if.sv | 30 +++
 rtl/axi_aw_arb3.sv | 161 ++++++++++++++++
 tb/tb_axi_aw_arb3.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_aw_arb3_if.sv
// AW bus bundle for the 3-to-1 write-address arbiter.
// slave  : the arbiter's view (takes the three upstream AW ports, drives the merged AW).
// master : the surrounding environment's view.
interface axi_aw_arb3_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
);
  logic [2:0]          s_awvalid;
  logic [2:0]          s_awready;
  logic [3*ADDR_W-1:0] s_awaddr;
  logic [3*ID_W-1:0]   s_awid;
  logic [3*LEN_W-1:0]  s_awlen;
  logic                m_awvalid;
  logic                m_awready;
  logic [ADDR_W-1:0]   m_awaddr;
  logic [ID_W-1:0]     m_awid;
  logic [LEN_W-1:0]    m_awlen;
  logic [1:0]          m_awsrc;

  modport slave (
    input  s_awvalid, s_awaddr, s_awid, s_awlen, m_awready,
    output s_awready, m_awvalid, m_awaddr, m_awid, m_awlen, m_awsrc
  );

  modport master (
    output s_awvalid, s_awaddr, s_awid, s_awlen, m_awready,
    input  s_awready, m_awvalid, m_awaddr, m_awid, m_awlen, m_awsrc
  );
endinterface

// File: rtl/axi_aw_arb3.sv
// 3-to-1 AXI AW arbiter with single-entry registered output slice.
// Modes: 0 fixed priority, 1 round robin (3 aliases 1), 2 weighted round robin.
// m_awsrc carries the winning port so W/B routing can follow AW order.
// Optional: define AXI_ARB_STARVE_MON_EN to add the starve_max monitor output.
module axi_aw_arb3 #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8,
  parameter int WGT_W  = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             arb_en,
  input  logic [1:0]       arb_mode,
  input  logic [WGT_W-1:0] weight0,
  input  logic [WGT_W-1:0] weight1,
  input  logic [WGT_W-1:0] weight2,
  axi_aw_arb3_if.slave     bus
`ifdef AXI_ARB_STARVE_MON_EN
  , output logic [3*WGT_W-1:0] starve_max
`endif
);

  logic [2:0]              v;
  logic [2:0][ADDR_W-1:0]  addr_a;
  logic [2:0][ID_W-1:0]    id_a;
  logic [2:0][LEN_W-1:0]   len_a;
  logic [2:0][WGT_W-1:0]   wgt;

  assign v      = bus.s_awvalid;
  assign addr_a = bus.s_awaddr;
  assign id_a   = bus.s_awid;
  assign len_a  = bus.s_awlen;
  assign wgt    = {weight2, weight1, weight0};

  logic [1:0]       last_q, last_d;
  logic [WGT_W-1:0] cons_q, cons_d;
  logic             en_q;
  logic [1:0]       mode_q;

  logic             mv_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  len_q;
  logic [1:0]        src_q;

  logic       slot_free, gnt_vld, hs, keep, cfg_chg;
  logic [1:0] gnt, rr1, rr2;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign slot_free = ~mv_q | bus.m_awready;
  assign rr1       = nxt(last_q);
  assign rr2       = nxt(rr1);
  // cons_q == 0 means the current run has not started yet (after reset or a
  // config change), so the previous winner gets no repeat credit.
  assign keep      = (arb_mode == 2'd2) && v[last_q] && (cons_q != '0) &&
                     (cons_q <= wgt[last_q]);
  assign cfg_chg   = (arb_en != en_q) || (arb_mode != mode_q);

  // Winner selection from current valids and arbitration history.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 2'd0;
    if (!arb_en) begin
      gnt_vld = v[0];
    end else begin
      gnt_vld = |v;
      if (arb_mode == 2'd0) begin
        if (v[0])      gnt = 2'd0;
        else if (v[1]) gnt = 2'd1;
        else           gnt = 2'd2;
      end else if (keep) begin
        gnt = last_q;
      end else if (v[rr1]) begin
        gnt = rr1;
      end else if (v[rr2]) begin
        gnt = rr2;
      end else begin
        gnt = last_q;
      end
    end
  end

  assign hs            = gnt_vld & slot_free;
  assign bus.s_awready = hs ? (3'b001 << gnt) : 3'b000;

  // History next-state: a config change restarts the consecutive-grant run.
  always_comb begin
    last_d = last_q;
    cons_d = cons_q;
    if (hs) last_d = gnt;
    if (cfg_chg) begin
      cons_d = hs ? WGT_W'(1) : '0;
    end else if (hs) begin
      if (gnt == last_q) cons_d = (&cons_q) ? cons_q : cons_q + WGT_W'(1);
      else               cons_d = WGT_W'(1);
    end
  end

  // Arbitration history registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_q <= 2'd2;
      cons_q <= '0;
      en_q   <= 1'b0;
      mode_q <= 2'd0;
    end else begin
      last_q <= last_d;
      cons_q <= cons_d;
      en_q   <= arb_en;
      mode_q <= arb_mode;
    end
  end

  // Output slice: load on handshake, drain when taken without a refill.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mv_q   <= 1'b0;
      addr_q <= '0;
      id_q   <= '0;
      len_q  <= '0;
      src_q  <= 2'd0;
    end else if (hs) begin
      mv_q   <= 1'b1;
      addr_q <= addr_a[gnt];
      id_q   <= id_a[gnt];
      len_q  <= len_a[gnt];
      src_q  <= gnt;
    end else if (bus.m_awready) begin
      mv_q   <= 1'b0;
    end
  end

  assign bus.m_awvalid = mv_q;
  assign bus.m_awaddr  = addr_q;
  assign bus.m_awid    = id_q;
  assign bus.m_awlen   = len_q;
  assign bus.m_awsrc   = src_q;

`ifdef AXI_ARB_STARVE_MON_EN
  for (genvar n = 0; n < 3; n++) begin : g_stv
    logic [WGT_W-1:0] cnt_q, max_q;
    // Per-port wait counter and its running maximum.
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        cnt_q <= '0;
        max_q <= '0;
      end else begin
        if (v[n] && !bus.s_awready[n]) cnt_q <= (&cnt_q) ? cnt_q : cnt_q + WGT_W'(1);
        else                           cnt_q <= '0;
        if (cnt_q > max_q) max_q <= cnt_q;
      end
    end
    assign starve_max[n*WGT_W +: WGT_W] = max_q;
  end
`endif

endmodule

// File: tb/tb_axi_aw_arb3.sv
// Randomized self-checking bench for axi_aw_arb3 with a behavioural model.
module tb_axi_aw_arb3;
  logic        aclk = 1'b0;
  logic        areset;
  logic        arb_en;
  logic [1:0]  arb_mode;
  logic [15:0] weight0, weight1, weight2;

  axi_aw_arb3_if #(.ADDR_W(32), .ID_W(4), .LEN_W(8)) bus ();

  axi_aw_arb3 #(.ADDR_W(32), .ID_W(4), .LEN_W(8), .WGT_W(16)) dut (
    .aclk(aclk), .areset(areset), .arb_en(arb_en), .arb_mode(arb_mode),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .bus(bus)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  // model state
  int          m_last, m_cons, e_gnt;
  bit          m_pen, e_mv, e_hs;
  bit   [1:0]  m_pmode, e_src;
  logic [2:0]  e_rdy;
  logic [31:0] e_addr;
  logic [3:0]  e_id;
  logic [7:0]  e_len;

  function automatic int wsel(input int p);
    case (p)
      0:       return int'(weight0);
      1:       return int'(weight1);
      default: return int'(weight2);
    endcase
  endfunction

  task automatic rnd_payload();
    bus.s_awaddr = {$urandom, $urandom, $urandom};
    bus.s_awid   = 12'($urandom);
    bus.s_awlen  = 24'($urandom);
  endtask

  task automatic model_reset();
    m_last = 2; m_cons = 0; m_pen = 0; m_pmode = 0;
    e_mv = 0; e_addr = 0; e_id = 0; e_len = 0; e_src = 0;
  endtask

  // Move to the sampling point and work out what the arbiter should do now.
  task automatic eval();
    int order [3];
    logic [2:0] v;
    int md;
    @(negedge aclk);
    v = bus.s_awvalid;
    md = (arb_mode == 2'd3) ? 1 : int'(arb_mode);
    order = '{(m_last + 1) % 3, (m_last + 2) % 3, m_last};
    e_gnt = -1;
    if (!arb_en) begin
      if (v[0]) e_gnt = 0;
    end else if (md == 0) begin
      for (int i = 0; i < 3; i++) if (e_gnt < 0 && v[i]) e_gnt = i;
    end else if (md == 2 && v[m_last] && m_cons > 0 && m_cons <= wsel(m_last)) begin
      e_gnt = m_last;
    end else begin
      for (int i = 0; i < 3; i++) if (e_gnt < 0 && v[order[i]]) e_gnt = order[i];
    end
    e_hs  = (e_gnt >= 0) && (!e_mv || bus.m_awready);
    e_rdy = e_hs ? (3'b001 << e_gnt) : 3'b000;
  endtask

  // Clock edge: commit model state with the inputs that were present at the edge.
  task automatic adv();
    @(posedge aclk);
    if (arb_en != m_pen || arb_mode != m_pmode) m_cons = e_hs ? 1 : 0;
    else if (e_hs) m_cons = (e_gnt == m_last) ? ((m_cons < 65535) ? m_cons + 1 : 65535) : 1;
    if (e_hs) m_last = e_gnt;
    m_pen = arb_en; m_pmode = arb_mode;
    if (e_hs) begin
      e_mv   = 1;
      e_addr = bus.s_awaddr[e_gnt*32 +: 32];
      e_id   = bus.s_awid[e_gnt*4 +: 4];
      e_len  = bus.s_awlen[e_gnt*8 +: 8];
      e_src  = 2'(e_gnt);
    end else if (bus.m_awready) begin
      e_mv = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    bus.s_awvalid = 3'b000; bus.m_awready = 1'b0;
    arb_en = 1'b1; arb_mode = 2'd0;
    weight0 = 0; weight1 = 0; weight2 = 0;
    rnd_payload();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    bus.s_awvalid = 3'b000; bus.m_awready = 1'b0;
    arb_en = 1'b1; arb_mode = 2'd0;
    weight0 = 0; weight1 = 0; weight2 = 0;
    rnd_payload();
    #12;
    tests++;
    if (bus.m_awvalid !== 1'b0 || bus.m_awaddr !== 32'd0 || bus.m_awid !== 4'd0 ||
        bus.m_awlen !== 8'd0 || bus.m_awsrc !== 2'd0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b a=%h id=%h len=%h src=%0d, want all zero",
               bus.m_awvalid, bus.m_awaddr, bus.m_awid, bus.m_awlen, bus.m_awsrc);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    model_reset();
  endtask

  task automatic test_fixed();
    do_reset();
    arb_en = 1; arb_mode = 0; bus.s_awvalid = 3'b111; bus.m_awready = 1;
    for (int i = 0; i < 8; i++) begin
      rnd_payload();
      eval();
      tests++;
      if (bus.s_awready !== 3'b001) begin
        fails++; $display("FAIL fixed_ready[%0d]: got %b want 001", i, bus.s_awready);
      end
      if (i > 0) begin
        tests++;
        if (bus.m_awvalid !== 1'b1 || bus.m_awsrc !== 2'd0 || bus.m_awaddr !== e_addr) begin
          fails++;
          $display("FAIL fixed_out[%0d]: got v=%b src=%0d a=%h want v=1 src=0 a=%h",
                   i, bus.m_awvalid, bus.m_awsrc, bus.m_awaddr, e_addr);
        end
      end
      adv();
    end
    bus.s_awvalid = 3'b110;
    eval();
    tests++;
    if (bus.s_awready !== 3'b010) begin
      fails++; $display("FAIL fixed_port1: got %b want 010", bus.s_awready);
    end
    adv();
  endtask

  task automatic test_seq(input logic [1:0] mode, input int w0, input int w1, input int w2,
                          input int n, input int exp_seq [9]);
    do_reset();
    arb_en = 1; arb_mode = mode; weight0 = 16'(w0); weight1 = 16'(w1); weight2 = 16'(w2);
    bus.s_awvalid = 3'b111; bus.m_awready = 1;
    rnd_payload();
    eval();
    tests++;
    if (bus.m_awvalid !== 1'b0 || bus.s_awready !== 3'b001) begin
      fails++;
      $display("FAIL seq_first m%0d: got v=%b rdy=%b want v=0 rdy=001",
               mode, bus.m_awvalid, bus.s_awready);
    end
    adv();
    for (int i = 0; i < n; i++) begin
      rnd_payload();
      eval();
      tests++;
      if (bus.m_awvalid !== 1'b1 || bus.m_awsrc !== 2'(exp_seq[i]) || bus.m_awaddr !== e_addr) begin
        fails++;
        $display("FAIL seq m%0d [%0d]: got v=%b src=%0d a=%h want v=1 src=%0d a=%h",
                 mode, i, bus.m_awvalid, bus.m_awsrc, bus.m_awaddr, exp_seq[i], e_addr);
      end
      adv();
    end
  endtask

  task automatic test_rr();
    int s [9] = '{0, 1, 2, 0, 1, 2, 0, 0, 0};
    test_seq(2'd1, 0, 0, 0, 6, s);
  endtask

  task automatic test_wrr();
    int s [9] = '{0, 0, 0, 1, 2, 2, 0, 0, 0};
    test_seq(2'd2, 2, 0, 1, 9, s);
  endtask

  task automatic test_stall();
    logic [31:0] held;
    do_reset();
    arb_en = 1; arb_mode = 1; bus.s_awvalid = 3'b111; bus.m_awready = 1;
    for (int i = 0; i < 3; i++) begin rnd_payload(); eval(); adv(); end
    held = e_addr;
    bus.m_awready = 0;
    for (int i = 0; i < 5; i++) begin
      rnd_payload();
      eval();
      tests++;
      if (bus.s_awready !== 3'b000 || bus.m_awvalid !== 1'b1 || bus.m_awaddr !== held ||
          bus.m_awsrc !== 2'd2) begin
        fails++;
        $display("FAIL stall[%0d]: got rdy=%b v=%b a=%h src=%0d want rdy=000 v=1 a=%h src=2",
                 i, bus.s_awready, bus.m_awvalid, bus.m_awaddr, bus.m_awsrc, held);
      end
      adv();
    end
    bus.m_awready = 1;
    eval();
    tests++;
    if (bus.s_awready !== 3'b001) begin
      fails++; $display("FAIL stall_release: got %b want 001", bus.s_awready);
    end
    adv();
    eval();
    tests++;
    if (bus.m_awvalid !== 1'b1 || bus.m_awsrc !== 2'd0 || bus.m_awaddr !== e_addr) begin
      fails++;
      $display("FAIL stall_next: got v=%b src=%0d a=%h want v=1 src=0 a=%h",
               bus.m_awvalid, bus.m_awsrc, bus.m_awaddr, e_addr);
    end
    adv();
  endtask

  task automatic test_arb_dis();
    int bad = 0;
    do_reset();
    arb_en = 0; arb_mode = 1; bus.s_awvalid = 3'b110; bus.m_awready = 1;
    for (int i = 0; i < 20; i++) begin
      eval();
      if (bus.s_awready !== 3'b000 || bus.m_awvalid !== 1'b0) bad++;
      adv();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL arb_dis_hold: %0d cycles with grant/valid, want 0", bad);
    end
    bus.s_awvalid = 3'b111;
    rnd_payload();
    eval();
    tests++;
    if (bus.s_awready !== 3'b001) begin
      fails++; $display("FAIL arb_dis_port0: got %b want 001", bus.s_awready);
    end
    adv();
    eval();
    tests++;
    if (bus.m_awvalid !== 1'b1 || bus.m_awsrc !== 2'd0 || bus.m_awaddr !== e_addr) begin
      fails++;
      $display("FAIL arb_dis_out: got v=%b src=%0d a=%h want v=1 src=0 a=%h",
               bus.m_awvalid, bus.m_awsrc, bus.m_awaddr, e_addr);
    end
    adv();
  endtask

  task automatic test_reset_mid();
    do_reset();
    arb_en = 1; arb_mode = 1; bus.s_awvalid = 3'b111; bus.m_awready = 1;
    for (int i = 0; i < 2; i++) begin rnd_payload(); eval(); adv(); end
    bus.m_awready = 0;
    #2;
    areset = 1'b1;
    #1;
    tests++;
    if (bus.m_awvalid !== 1'b0 || bus.m_awaddr !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid: got v=%b a=%h want v=0 a=0", bus.m_awvalid, bus.m_awaddr);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    model_reset();
    bus.m_awready = 1;
    eval();
    tests++;
    if (bus.s_awready !== 3'b001) begin
      fails++; $display("FAIL reset_mid_first: got %b want 001", bus.s_awready);
    end
    adv();
    eval();
    tests++;
    if (bus.m_awvalid !== 1'b1 || bus.m_awsrc !== 2'd0) begin
      fails++;
      $display("FAIL reset_mid_src: got v=%b src=%0d want v=1 src=0", bus.m_awvalid, bus.m_awsrc);
    end
    adv();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) arb_mode = 2'($urandom_range(0, 3));
      if (c % 25 == 0) begin
        weight0 = 16'($urandom_range(0, 3));
        weight1 = 16'($urandom_range(0, 3));
        weight2 = 16'($urandom_range(0, 3));
      end
      arb_en        = ($urandom_range(0, 15) != 0);
      bus.s_awvalid = 3'($urandom);
      bus.m_awready = ($urandom_range(0, 3) != 0);
      rnd_payload();
      eval();
      tests++;
      if (bus.s_awready !== e_rdy || bus.m_awvalid !== e_mv) begin
        fails++;
        $display("FAIL rand_hs[%0d]: got rdy=%b v=%b want rdy=%b v=%b",
                 c, bus.s_awready, bus.m_awvalid, e_rdy, e_mv);
      end
      if (e_mv) begin
        tests++;
        if (bus.m_awaddr !== e_addr || bus.m_awid !== e_id || bus.m_awlen !== e_len ||
            bus.m_awsrc !== e_src) begin
          fails++;
          $display("FAIL rand_pay[%0d]: got a=%h id=%h len=%h src=%0d want a=%h id=%h len=%h src=%0d",
                   c, bus.m_awaddr, bus.m_awid, bus.m_awlen, bus.m_awsrc,
                   e_addr, e_id, e_len, e_src);
        end
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr();
    test_wrr();
    test_stall();
    test_arb_dis();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
